weight_rrdispatcher: RTL and testbench

WEIGHT_RRDISPATCHER -- requirements
Module: weight_rrdispatcher

---
 rtl/weight_rr_pkg.sv | 30 +++
 rtl/weight_rr_nextptr.sv | 40 ++++
 rtl/weight_rrdispatcher.sv | 151 +++++++++++++++
 tb/tb_weight_rrdispatcher.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_rr_pkg.sv
// ---------------------------------------------------------------------------
// weight_rr_pkg : default parameters and shared types for the weighted
//                 round-robin arbiter/dispatcher pair.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package weight_rr_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WBITS_DEF = 4;
  localparam int WDATA_DEF = 32;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W_DEF = ptr_width(NREQ_DEF);

  typedef logic [NREQ_DEF*WBITS_DEF-1:0] weight_vec_t;
  typedef logic [PTR_W_DEF-1:0]          ptr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/weight_rr_nextptr.sv
// ---------------------------------------------------------------------------
// weight_rr_nextptr : combinational circular search for the first port after
//                     cur whose weight is non-zero (cur itself is tried last).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module weight_rr_nextptr
  import weight_rr_pkg::*;
#(
  parameter int nReq  = NREQ_DEF,
  parameter int wBits = WBITS_DEF,
  parameter int PTR_W = ptr_width(NREQ_DEF)
) (
  input  logic [nReq*wBits-1:0] weights,
  input  logic [PTR_W-1:0]      cur,
  output logic [PTR_W-1:0]      nxt,
  output logic                  found
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is kept.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = nReq; i >= 1; i--) begin
      idx = int'(cur) + i;
      if (idx >= nReq) idx = idx - nReq;
      if (weights[idx*wBits +: wBits] != '0) begin
        nxt   = PTR_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/weight_rrdispatcher.sv
// ---------------------------------------------------------------------------
// weight_rrdispatcher : 1-to-N weighted round-robin stream dispatcher with a
//                       single registered output stage.
// Optional: WEIGHT_RRDISPATCHER_STATS_EN adds per-port beat_count outputs.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module weight_rrdispatcher
  import weight_rr_pkg::*;
#(
  parameter int nReq  = NREQ_DEF,
  parameter int wBits = WBITS_DEF,
  parameter int wData = WDATA_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [wData-1:0]      in_data,
  output logic [nReq-1:0]       out_valid,
  input  logic [nReq-1:0]       out_ready,
  output logic [wData-1:0]      out_data,
  input  logic                  weight_update,
  input  logic [nReq*wBits-1:0] weights
`ifdef WEIGHT_RRDISPATCHER_STATS_EN
  ,
  output logic [nReq*32-1:0]    beat_count
`endif
);

  localparam int PTR_W = ptr_width(nReq);

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q,   ptr_d;
  logic [wBits-1:0]       cnt_q,   cnt_d;
  logic [nReq*wBits-1:0]  wreg_q,  wreg_d;
  logic [nReq-1:0]        vld_q,   vld_d;
  logic [wData-1:0]       data_q,  data_d;

  logic                   any_w;
  logic                   out_fire;
  logic                   accept;
  logic [wBits-1:0]       cnt_inc;
  logic [PTR_W-1:0]       adv_ptr;
  logic                   adv_found;
  logic [PTR_W-1:0]       low_ptr;
  logic                   low_found;

  weight_rr_nextptr #(.nReq(nReq), .wBits(wBits), .PTR_W(PTR_W)) u_adv (
    .weights (wreg_q),
    .cur     (ptr_q),
    .nxt     (adv_ptr),
    .found   (adv_found)
  );

  // Searching after the last index yields the lowest-index non-zero port.
  weight_rr_nextptr #(.nReq(nReq), .wBits(wBits), .PTR_W(PTR_W)) u_low (
    .weights (weights),
    .cur     (PTR_W'(nReq - 1)),
    .nxt     (low_ptr),
    .found   (low_found)
  );

  assign any_w     = |wreg_q;
  assign out_fire  = |(vld_q & out_ready);
  assign in_ready  = (state_q == RUN) && ((vld_q == '0) || out_fire);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  assign out_valid = vld_q;
  assign out_data  = data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger && any_w) state_d = RUN;
      RUN:     if (!trigger || !any_w) state_d = DRAIN;
      DRAIN: begin
        if (trigger && any_w)  state_d = RUN;
        else if (vld_q == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (accept) begin
      vld_d        = '0;
      vld_d[ptr_q] = 1'b1;
      data_d       = in_data;
    end else if (out_fire) begin
      vld_d  = '0;
      data_d = '0;
    end
  end

  // A weight load wins over the credit update of a beat taken in that cycle.
  always_comb begin
    wreg_d = wreg_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    if (weight_update) begin
      wreg_d = weights;
      cnt_d  = '0;
      ptr_d  = low_found ? low_ptr : '0;
    end else if (accept) begin
      if (cnt_inc == wreg_q[ptr_q*wBits +: wBits]) begin
        cnt_d = '0;
        ptr_d = adv_found ? adv_ptr : '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < nReq; i++) wreg_q[i*wBits +: wBits] <= wBits'(1);
      vld_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wreg_q  <= wreg_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

`ifdef WEIGHT_RRDISPATCHER_STATS_EN
  for (genvar g = 0; g < nReq; g++) begin : g_stats
    logic [31:0] bc_q, bc_d;
    always_comb bc_d = bc_q + ((vld_q[g] && out_ready[g]) ? 32'd1 : 32'd0);
    always_ff @(posedge clock) begin
      if (reset) bc_q <= '0;
      else       bc_q <= bc_d;
    end
    assign beat_count[g*32 +: 32] = bc_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_rrdispatcher.sv
// ---------------------------------------------------------------------------
// tb_weight_rrdispatcher : directed self-checking bench for weight_rrdispatcher.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_weight_rrdispatcher;
  import weight_rr_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        trigger;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        weight_update;
  weight_vec_t weights;
`ifdef WEIGHT_RRDISPATCHER_STATS_EN
  logic [127:0] beat_count;
`endif

  weight_rrdispatcher dut (
    .clock         (clock),
    .reset         (reset),
    .trigger       (trigger),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .weight_update (weight_update),
    .weights       (weights)
`ifdef WEIGHT_RRDISPATCHER_STATS_EN
    ,
    .beat_count    (beat_count)
`endif
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_err    = 0;
  int          dport[$];
  logic [31:0] ddata[$];
  logic [3:0]  seen_valid;
  int          acc_cnt;
  logic [31:0] held;
  bit          found;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes just before the edge, then land 1 after it.
  task automatic step();
    logic       acc;
    logic [3:0] del;
    #1;
    acc = in_valid && in_ready;
    del = out_valid & out_ready;
    seen_valid = seen_valid | out_valid;
    for (int i = 0; i < 4; i++) begin
      if (del[i]) begin
        dport.push_back(i);
        ddata.push_back(out_data);
      end
    end
    @(posedge clock);
    #1;
    if (acc) begin
      in_data = in_data + 1;
      acc_cnt++;
    end
  endtask

  task automatic clear_log();
    dport.delete();
    ddata.delete();
    seen_valid = '0;
    acc_cnt    = 0;
  endtask

  task automatic load_weights(input weight_vec_t w);
    weights       = w;
    weight_update = 1'b1;
    step();
    weight_update = 1'b0;
  endtask

  int exp1234 [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
  int exp2001 [3]  = '{0, 0, 3};

  initial begin
    reset = 1'b1; trigger = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 4'hF; weight_update = 1'b0; weights = '0;
    clear_log();
    repeat (2) step();
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 4'h0);
    check_eq("rst_out_data",  out_data,  32'h0);
    check_eq("rst_in_ready",  in_ready,  1'b0);
    check_eq("rst_state",     dut.state_q, IDLE);
    check_eq("rst_ptr",       dut.ptr_q, 2'd0);
    check_eq("rst_cnt",       dut.cnt_q, 4'd0);
    check_eq("rst_wreg",      dut.wreg_q, 16'h1111);

    // Weights 1,2,3,4 with continuous traffic
    load_weights({4'd4, 4'd3, 4'd2, 4'd1});
    trigger = 1'b1;
    step();
    check_eq("idle_to_run", dut.state_q, RUN);
    clear_log();
    in_data = 32'd100; in_valid = 1'b1;
    repeat (22) step();
    check_eq("t1_count", dport.size() >= 20, 1'b1);
    for (int k = 0; k < 20 && k < dport.size(); k++) begin
      check_eq($sformatf("t1_port%0d", k), dport[k], exp1234[k % 10]);
      check_eq($sformatf("t1_data%0d", k), ddata[k], 32'd100 + k);
    end

    // Weights 2,0,0,1: ports 1 and 2 are disabled
    in_valid = 1'b0;
    repeat (2) step();
    load_weights({4'd1, 4'd0, 4'd0, 4'd2});
    clear_log();
    in_data = 32'd200; in_valid = 1'b1;
    repeat (14) step();
    check_eq("t2_count", dport.size() >= 12, 1'b1);
    for (int k = 0; k < 12 && k < dport.size(); k++)
      check_eq($sformatf("t2_port%0d", k), dport[k], exp2001[k % 3]);
    check_eq("t2_port1_never", seen_valid[1], 1'b0);
    check_eq("t2_port2_never", seen_valid[2], 1'b0);

    // Backpressure on port 1 while its beat is held
    in_valid = 1'b0;
    repeat (2) step();
    load_weights({4'd4, 4'd3, 4'd2, 4'd1});
    clear_log();
    in_data = 32'd300; out_ready = 4'b1101; in_valid = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (out_valid == 4'b0010) found = 1'b1;
      else step();
    end
    check_eq("t3_hold_seen", found, 1'b1);
    held = out_data;
    check_eq("t3_held_data", held, 32'd301);
    for (int t = 0; t < 5; t++) begin
      check_eq($sformatf("t3_in_ready%0d", t), in_ready, 1'b0);
      check_eq($sformatf("t3_vld%0d", t), out_valid, 4'b0010);
      check_eq($sformatf("t3_data%0d", t), out_data, held);
      step();
    end
    out_ready = 4'hF;
    repeat (12) step();
    check_eq("t3_count", dport.size() >= 10, 1'b1);
    for (int k = 0; k < 10 && k < dport.size(); k++) begin
      check_eq($sformatf("t3_port%0d", k), dport[k], exp1234[k]);
      check_eq($sformatf("t3_seq%0d", k), ddata[k], 32'd300 + k);
    end

    // Trigger dropped while a beat is held
    out_ready = 4'h0; in_valid = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (out_valid != 4'h0) found = 1'b1;
      else step();
    end
    check_eq("t4_hold_seen", found, 1'b1);
    held = out_data;
    in_valid = 1'b0; trigger = 1'b0;
    step();
    check_eq("t4_state_drain", dut.state_q, DRAIN);
    check_eq("t4_still_held", out_valid != 4'h0, 1'b1);
    check_eq("t4_in_ready", in_ready, 1'b0);
    clear_log();
    out_ready = 4'hF;
    step();
    check_eq("t4_delivered", dport.size(), 1);
    if (dport.size() > 0) check_eq("t4_deliv_data", ddata[0], held);
    step();
    check_eq("t4_state_idle", dut.state_q, IDLE);
    check_eq("t4_idle_in_ready", in_ready, 1'b0);
    check_eq("t4_idle_vld", out_valid, 4'h0);
    check_eq("t4_idle_data", out_data, 32'h0);

    // Weight update mid-round: 1,2,3,4 -> 4,0,0,0
    load_weights({4'd4, 4'd3, 4'd2, 4'd1});
    trigger = 1'b1;
    step();
    clear_log();
    in_data = 32'd500; in_valid = 1'b1;
    for (int t = 0; t < 10 && acc_cnt < 3; t++) step();
    check_eq("t5_pre_accepts", acc_cnt, 3);
    load_weights({4'd0, 4'd0, 4'd0, 4'd4});
    check_eq("t5_cnt_restart", dut.cnt_q, 4'd0);
    check_eq("t5_ptr_port0", dut.ptr_q, 2'd0);
    step();
    check_eq("t5_cnt_one", dut.cnt_q, 4'd1);
    repeat (10) step();
    check_eq("t5_count", dport.size() >= 12, 1'b1);
    for (int k = 0; k < 12 && k < dport.size(); k++) begin
      check_eq($sformatf("t5_port%0d", k), dport[k], (k < 4) ? exp1234[k] : 0);
      check_eq($sformatf("t5_seq%0d", k), ddata[k], 32'd500 + k);
    end

    // Reset with a held beat drops it
    out_ready = 4'h0;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (out_valid != 4'h0) found = 1'b1;
      else step();
    end
    check_eq("t6_hold_seen", found, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check_eq("t6_vld", out_valid, 4'h0);
    check_eq("t6_data", out_data, 32'h0);
    check_eq("t6_ptr", dut.ptr_q, 2'd0);
    check_eq("t6_cnt", dut.cnt_q, 4'd0);
    check_eq("t6_state", dut.state_q, IDLE);
    check_eq("t6_in_ready", in_ready, 1'b0);
    check_eq("t6_wreg", dut.wreg_q, 16'h1111);
    clear_log();
    out_ready = 4'hF;
    repeat (3) step();
    check_eq("t6_dropped", dport.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
